// File: rtl/vx_sp_ram_ctrl_pkg.sv
// Shared types for the VX_sp_ram request front-end: controller state and
// sizing helpers for the response buffer.
package vx_sp_ram_ctrl_pkg;

    typedef enum logic [0:0] {
        ST_CLEAR = 1'b0,
        ST_RUN   = 1'b1
    } state_e;

    // Width of one packed response entry {data, tag}.
    function automatic int unsigned rsp_entry_width(input int unsigned dataw,
                                                    input int unsigned tagw);
        return dataw + tagw;
    endfunction

endpackage

// File: rtl/vx_sp_ram_ctrl_if.sv
// Request/response valid-ready bundle between a requester (master) and the
// sp_ram controller (slave).
interface vx_sp_ram_ctrl_if #(
    parameter int DATAW   = 32,
    parameter int ADDRW   = 8,
    parameter int BYTEENW = 4,
    parameter int TAGW    = 8
);
    logic               req_valid;
    logic               req_rw;
    logic [ADDRW-1:0]   req_addr;
    logic [BYTEENW-1:0] req_byteen;
    logic [DATAW-1:0]   req_data;
    logic [TAGW-1:0]    req_tag;
    logic               req_ready;

    logic               rsp_valid;
    logic [DATAW-1:0]   rsp_data;
    logic [TAGW-1:0]    rsp_tag;
    logic               rsp_ready;

    modport master (
        output req_valid, req_rw, req_addr, req_byteen, req_data, req_tag, rsp_ready,
        input  req_ready, rsp_valid, rsp_data, rsp_tag
    );

    modport slave (
        input  req_valid, req_rw, req_addr, req_byteen, req_data, req_tag, rsp_ready,
        output req_ready, rsp_valid, rsp_data, rsp_tag
    );

endinterface

// File: rtl/vx_sp_ram_ctrl_chk.sv
// Protocol checker for the response FIFO: the credit scheme must keep it from
// ever overflowing or underflowing.
module vx_fifo_queue_chk (
    input logic clk,
    input logic reset_n,
    input logic push,
    input logic pop,
    input logic full,
    input logic empty
);

    a_no_overflow: assert property (@(posedge clk) disable iff (!reset_n) !(push && full));
    a_no_underflow: assert property (@(posedge clk) disable iff (!reset_n) !(pop && empty));

endmodule

// File: rtl/vx_sp_ram_ctrl_fifo.sv
// Response buffer: single-push/single-pop FIFO with first-word-fall-through
// output; DEPTH need not be a power of two.
module vx_fifo_queue #(
    parameter int WIDTH = 40,
    parameter int DEPTH = 2
) (
    input  logic             clk,
    input  logic             reset_n,
    input  logic             push,
    input  logic             pop,
    input  logic [WIDTH-1:0] din,
    output logic [WIDTH-1:0] dout,
    output logic             empty
);

    localparam int PTRW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int CNTW = $clog2(DEPTH + 1);

    logic [WIDTH-1:0] mem_r [DEPTH];
    logic [PTRW-1:0]  wr_ptr_r;
    logic [PTRW-1:0]  rd_ptr_r;
    logic [CNTW-1:0]  count_r;
    logic             full_s;
    logic             do_push_s;
    logic             do_pop_s;

    function automatic logic [PTRW-1:0] ptr_inc(input logic [PTRW-1:0] p);
        return (p == PTRW'(DEPTH - 1)) ? {PTRW{1'b0}} : p + PTRW'(1);
    endfunction

    assign empty     = (count_r == {CNTW{1'b0}});
    assign full_s    = (count_r == CNTW'(DEPTH));
    assign do_push_s = push & ~full_s;
    assign do_pop_s  = pop & ~empty;
    assign dout      = mem_r[rd_ptr_r];

    // Pointer and occupancy tracking.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            wr_ptr_r <= {PTRW{1'b0}};
            rd_ptr_r <= {PTRW{1'b0}};
            count_r  <= {CNTW{1'b0}};
        end else begin
            if (do_push_s) wr_ptr_r <= ptr_inc(wr_ptr_r);
            if (do_pop_s)  rd_ptr_r <= ptr_inc(rd_ptr_r);
            case ({do_push_s, do_pop_s})
                2'b10:   count_r <= count_r + CNTW'(1);
                2'b01:   count_r <= count_r - CNTW'(1);
                default: count_r <= count_r;
            endcase
        end
    end

    // Entry storage; slots are only read after being written.
    always_ff @(posedge clk) begin
        if (do_push_s) mem_r[wr_ptr_r] <= din;
    end

    vx_fifo_queue_chk u_chk (
        .clk     (clk),
        .reset_n (reset_n),
        .push    (push),
        .pop     (pop),
        .full    (full_s),
        .empty   (empty)
    );

endmodule

// File: rtl/vx_sp_ram_ctrl.sv
// Request front-end for VX_sp_ram: post-reset clear sweep, one RAM access per
// cycle, and credit-protected in-order responses.
module vx_sp_ram_ctrl
    import vx_sp_ram_ctrl_pkg::*;
#(
    parameter int               DATAW      = 32,
    parameter int               SIZE       = 256,
    parameter int               BYTEENW    = 4,
    parameter int               ADDRW      = $clog2(SIZE),
    parameter int               TAGW       = 8,
    parameter int               OUT_REG    = 0,
    parameter int               RSP_DEPTH  = 2,
    parameter int               WRITE_ACK  = 0,
    parameter int               INIT_CLEAR = 1,
    parameter logic [DATAW-1:0] INIT_VALUE = {DATAW{1'b0}}
) (
    input  logic               clk,
    input  logic               reset_n,
    vx_sp_ram_ctrl_if.slave    bus,
    output logic               init_done,
    output logic [ADDRW-1:0]   ram_addr,
    output logic [BYTEENW-1:0] ram_wren,
    output logic [DATAW-1:0]   ram_wdata,
    input  logic [DATAW-1:0]   ram_rdata
);

    localparam int               CRW         = $clog2(RSP_DEPTH + 1);
    localparam int               RSPW        = rsp_entry_width(DATAW, TAGW);
    localparam logic [CRW-1:0]   CREDIT_FULL = CRW'(RSP_DEPTH);
    localparam logic [ADDRW-1:0] CLR_LAST    = ADDRW'(SIZE - 1);
    localparam logic [DATAW-1:0] ZERO_DATA   = {DATAW{1'b0}};
    localparam logic             ACK_WRITES  = (WRITE_ACK != 0);
    localparam state_e           ST_INIT     = (INIT_CLEAR != 0) ? ST_CLEAR : ST_RUN;

    typedef struct packed {
        logic [DATAW-1:0] data;
        logic [TAGW-1:0]  tag;
    } rsp_entry_t;

    state_e             state_r, state_s;
    logic [ADDRW-1:0]   clr_addr_r, clr_addr_s;
    logic [CRW-1:0]     credit_r, credit_s;
    logic               ready_r, ready_s;
    logic               init_done_r;
    logic               fire_s;
    logic               credit_dec_s;
    logic               rsp_take_s;
    logic [ADDRW-1:0]   addr_s;
    logic [DATAW-1:0]   wdata_s;
    logic [BYTEENW-1:0] wren_s;
    logic               push_s;
    rsp_entry_t         push_entry_s;
    rsp_entry_t         pop_entry_s;
    logic [RSPW-1:0]    pop_vec_s;
    logic               fifo_empty_s;

    assign fire_s       = bus.req_valid & ready_r;
    assign credit_dec_s = fire_s & (~bus.req_rw | ACK_WRITES);
    assign rsp_take_s   = ~fifo_empty_s & bus.rsp_ready;

    // Next-state and RAM port drive: sweep in CLEAR, pass requests through in RUN.
    always_comb begin
        state_s    = state_r;
        clr_addr_s = clr_addr_r;
        addr_s     = bus.req_addr;
        wdata_s    = bus.req_data;
        wren_s     = {BYTEENW{1'b0}};
        case (state_r)
            ST_CLEAR: begin
                addr_s  = clr_addr_r;
                wdata_s = INIT_VALUE;
                wren_s  = {BYTEENW{1'b1}};
                if (clr_addr_r == CLR_LAST) begin
                    state_s = ST_RUN;
                end else begin
                    clr_addr_s = clr_addr_r + ADDRW'(1);
                end
            end
            ST_RUN: begin
                if (fire_s && bus.req_rw) begin
                    wren_s = bus.req_byteen;
                end else begin
                    wren_s = {BYTEENW{1'b0}};
                end
            end
            default: begin
                state_s = ST_INIT;
            end
        endcase
    end

    // Credit bookkeeping; a freed credit only reaches req_ready on the next cycle.
    always_comb begin
        case ({credit_dec_s, rsp_take_s})
            2'b10:   credit_s = credit_r - CRW'(1);
            2'b01:   credit_s = credit_r + CRW'(1);
            default: credit_s = credit_r;
        endcase
        ready_s = (state_s == ST_RUN) && (credit_s != {CRW{1'b0}});
    end

    // Controller state registers.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_r     <= ST_INIT;
            clr_addr_r  <= {ADDRW{1'b0}};
            credit_r    <= CREDIT_FULL;
            ready_r     <= 1'b0;
            init_done_r <= (INIT_CLEAR == 0);
        end else begin
            state_r     <= state_s;
            clr_addr_r  <= clr_addr_s;
            credit_r    <= credit_s;
            ready_r     <= ready_s;
            init_done_r <= (state_s == ST_RUN);
        end
    end

    // Acks ride the same stage as reads when the RAM read is registered, so a
    // single FIFO push per cycle keeps responses in request order.
    if (OUT_REG != 0) begin : g_out_reg
        logic            s1_valid_r;
        logic            s1_ack_r;
        logic [TAGW-1:0] s1_tag_r;

        // Hold valid/tag until the registered read data arrives.
        always_ff @(posedge clk or negedge reset_n) begin
            if (!reset_n) begin
                s1_valid_r <= 1'b0;
                s1_ack_r   <= 1'b0;
                s1_tag_r   <= {TAGW{1'b0}};
            end else begin
                s1_valid_r <= credit_dec_s;
                s1_ack_r   <= bus.req_rw;
                s1_tag_r   <= bus.req_tag;
            end
        end

        assign push_s       = s1_valid_r;
        assign push_entry_s = {(s1_ack_r ? ZERO_DATA : ram_rdata), s1_tag_r};
    end else begin : g_out_comb
        assign push_s       = credit_dec_s;
        assign push_entry_s = {(bus.req_rw ? ZERO_DATA : ram_rdata), bus.req_tag};
    end

    vx_fifo_queue #(
        .WIDTH (RSPW),
        .DEPTH (RSP_DEPTH)
    ) u_rsp_fifo (
        .clk     (clk),
        .reset_n (reset_n),
        .push    (push_s),
        .pop     (rsp_take_s),
        .din     (push_entry_s),
        .dout    (pop_vec_s),
        .empty   (fifo_empty_s)
    );

    assign pop_entry_s   = rsp_entry_t'(pop_vec_s);
    assign bus.req_ready = ready_r;
    assign bus.rsp_valid = ~fifo_empty_s;
    assign bus.rsp_data  = pop_entry_s.data;
    assign bus.rsp_tag   = pop_entry_s.tag;
    assign init_done     = init_done_r;
    assign ram_addr      = addr_s;
    assign ram_wdata     = wdata_s;
    assign ram_wren      = reset_n ? wren_s : {BYTEENW{1'b0}};

endmodule

// File: tb/tb_vx_sp_ram_ctrl.sv
// Scoreboard bench: instance A (comb RAM read, no write acks) and instance B
// (registered read, write acks), each beside a behavioural sp_ram model.
module tb_vx_sp_ram_ctrl;

    localparam logic [31:0] INIT_A = 32'hC0FF_EE00;
    localparam logic [31:0] INIT_B = 32'h1111_2222;

    typedef struct packed {
        logic [31:0] data;
        logic [7:0]  tag;
    } rsp_t;

    logic clk;
    logic reset_n;
    int   total = 0;
    int   bad   = 0;
    rsp_t exp_a[$];
    rsp_t exp_b[$];
    rsp_t mon_a;
    rsp_t mon_b;

    logic        init_done_a, init_done_b;
    logic [3:0]  ram_addr_a, ram_addr_b;
    logic [3:0]  ram_wren_a, ram_wren_b;
    logic [31:0] ram_wdata_a, ram_wdata_b;
    logic [31:0] ram_rdata_a, ram_rdata_b;
    logic [31:0] mem_a [16];
    logic [31:0] mem_b [16];

    vx_sp_ram_ctrl_if #(.DATAW(32), .ADDRW(4), .BYTEENW(4), .TAGW(8)) bus_a ();
    vx_sp_ram_ctrl_if #(.DATAW(32), .ADDRW(4), .BYTEENW(4), .TAGW(8)) bus_b ();

    vx_sp_ram_ctrl #(
        .DATAW(32), .SIZE(16), .BYTEENW(4), .ADDRW(4), .TAGW(8), .OUT_REG(0),
        .RSP_DEPTH(2), .WRITE_ACK(0), .INIT_CLEAR(1), .INIT_VALUE(INIT_A)
    ) dut_a (
        .clk(clk), .reset_n(reset_n), .bus(bus_a), .init_done(init_done_a),
        .ram_addr(ram_addr_a), .ram_wren(ram_wren_a), .ram_wdata(ram_wdata_a),
        .ram_rdata(ram_rdata_a)
    );

    vx_sp_ram_ctrl #(
        .DATAW(32), .SIZE(16), .BYTEENW(4), .ADDRW(4), .TAGW(8), .OUT_REG(1),
        .RSP_DEPTH(2), .WRITE_ACK(1), .INIT_CLEAR(1), .INIT_VALUE(INIT_B)
    ) dut_b (
        .clk(clk), .reset_n(reset_n), .bus(bus_b), .init_done(init_done_b),
        .ram_addr(ram_addr_b), .ram_wren(ram_wren_b), .ram_wdata(ram_wdata_b),
        .ram_rdata(ram_rdata_b)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // RAM A: byte-write, combinational read.
    always @(posedge clk) begin
        for (int b = 0; b < 4; b++)
            if (ram_wren_a[b]) mem_a[ram_addr_a][8*b +: 8] <= ram_wdata_a[8*b +: 8];
    end
    assign ram_rdata_a = mem_a[ram_addr_a];

    // RAM B: byte-write, registered read.
    always @(posedge clk) begin
        for (int b = 0; b < 4; b++)
            if (ram_wren_b[b]) mem_b[ram_addr_b][8*b +: 8] <= ram_wdata_b[8*b +: 8];
        ram_rdata_b <= mem_b[ram_addr_b];
    end

    // Response monitors: every handshake must match the head of the scoreboard.
    always @(negedge clk) begin
        if (bus_a.rsp_valid && bus_a.rsp_ready) begin
            total++;
            if (exp_a.size() == 0) begin
                bad++;
                $display("FAIL rsp_a_unexpected: got data=%h tag=%h, none expected",
                         bus_a.rsp_data, bus_a.rsp_tag);
            end else begin
                mon_a = exp_a.pop_front();
                if (bus_a.rsp_data !== mon_a.data || bus_a.rsp_tag !== mon_a.tag) begin
                    bad++;
                    $display("FAIL rsp_a: got data=%h tag=%h expected data=%h tag=%h",
                             bus_a.rsp_data, bus_a.rsp_tag, mon_a.data, mon_a.tag);
                end
            end
        end
    end

    always @(negedge clk) begin
        if (bus_b.rsp_valid && bus_b.rsp_ready) begin
            total++;
            if (exp_b.size() == 0) begin
                bad++;
                $display("FAIL rsp_b_unexpected: got data=%h tag=%h, none expected",
                         bus_b.rsp_data, bus_b.rsp_tag);
            end else begin
                mon_b = exp_b.pop_front();
                if (bus_b.rsp_data !== mon_b.data || bus_b.rsp_tag !== mon_b.tag) begin
                    bad++;
                    $display("FAIL rsp_b: got data=%h tag=%h expected data=%h tag=%h",
                             bus_b.rsp_data, bus_b.rsp_tag, mon_b.data, mon_b.tag);
                end
            end
        end
    end

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
        total++;
        if (act !== req) begin
            bad++;
            $display("FAIL %s: got %h expected %h", name, act, req);
        end
    endtask

    task automatic drive(input bit sel, input logic v, input logic rw, input logic [3:0] addr,
                         input logic [3:0] be, input logic [31:0] data, input logic [7:0] tag);
        if (sel == 1'b0) begin
            bus_a.req_valid = v; bus_a.req_rw = rw; bus_a.req_addr = addr;
            bus_a.req_byteen = be; bus_a.req_data = data; bus_a.req_tag = tag;
        end else begin
            bus_b.req_valid = v; bus_b.req_rw = rw; bus_b.req_addr = addr;
            bus_b.req_byteen = be; bus_b.req_data = data; bus_b.req_tag = tag;
        end
    endtask

    // Hold a request until accepted; the expected response is queued at acceptance.
    task automatic send(input bit sel, input logic rw, input logic [3:0] addr,
                        input logic [3:0] be, input logic [31:0] data, input logic [7:0] tag,
                        input logic [31:0] exp_data, input bit exp_rsp);
        int   n = 0;
        bit   got = 1'b0;
        rsp_t e;
        drive(sel, 1'b1, rw, addr, be, data, tag);
        while (!got && n < 64) begin
            @(negedge clk);
            got = (sel == 1'b0) ? bus_a.req_ready : bus_b.req_ready;
            n++;
        end
        if (!got) begin
            total++;
            bad++;
            $display("FAIL req_accept: dut=%0d tag=%h not accepted within 64 cycles", sel, tag);
        end else if (exp_rsp) begin
            e.data = exp_data;
            e.tag  = tag;
            if (sel == 1'b0) exp_a.push_back(e);
            else             exp_b.push_back(e);
        end
        @(posedge clk);
        #1;
        drive(sel, 1'b0, 1'b0, 4'h0, 4'h0, 32'h0, 8'h00);
    endtask

    task automatic drain();
        int n = 0;
        while ((exp_a.size() != 0 || exp_b.size() != 0) && n < 200) begin
            @(posedge clk);
            n++;
        end
        #1;
        check("drain_a", exp_a.size(), 32'd0);
        check("drain_b", exp_b.size(), 32'd0);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        reset_n = 1'b0;
        drive(1'b0, 1'b0, 1'b0, 4'h0, 4'h0, 32'h0, 8'h00);
        drive(1'b1, 1'b0, 1'b0, 4'h0, 4'h0, 32'h0, 8'h00);
        bus_a.rsp_ready = 1'b1;
        bus_b.rsp_ready = 1'b1;
        repeat (3) @(posedge clk);
        #1;
        check("rst_req_ready", bus_a.req_ready, 32'd0);
        check("rst_rsp_valid", bus_a.rsp_valid, 32'd0);
        check("rst_init_done", init_done_a, 32'd0);
        check("rst_wren", ram_wren_a, 32'h0);

        // Clear sweep: init_done rises exactly 16 cycles after release.
        @(negedge clk);
        reset_n = 1'b1;
        for (int k = 1; k <= 16; k++) begin
            @(posedge clk);
            #1;
            if (k == 3) begin
                check("sweep_addr", ram_addr_a, 32'd3);
                check("sweep_wren", ram_wren_a, 32'hF);
                check("sweep_wdata", ram_wdata_a, INIT_A);
            end
            if (k == 15) check("init_done_k15", init_done_a, 32'd0);
        end
        check("init_done_k16", init_done_a, 32'd1);
        check("init_done_b", init_done_b, 32'd1);
        check("ready_after_init", bus_a.req_ready, 32'd1);
        send(1'b0, 1'b0, 4'd5, 4'h0, 32'h0, 8'h01, INIT_A, 1'b1);

        // Byte-enable merge and write-then-read, response at T+1.
        send(1'b0, 1'b1, 4'd3, 4'hF, 32'hDEAD_BEEF, 8'h02, 32'h0, 1'b0);
        send(1'b0, 1'b1, 4'd3, 4'h1, 32'h0000_00AA, 8'h03, 32'h0, 1'b0);
        send(1'b0, 1'b0, 4'd3, 4'h0, 32'h0, 8'h07, 32'hDEAD_BEAA, 1'b1);
        check("raw_valid_t1", bus_a.rsp_valid, 32'd1);
        check("raw_tag_t1", bus_a.rsp_tag, 32'h07);
        check("raw_data_t1", bus_a.rsp_data, 32'hDEAD_BEAA);
        drain();

        // Credit exhaustion under back-pressure, then in-order release.
        bus_a.rsp_ready = 1'b0;
        fork
            for (int i = 0; i < 8; i++)
                send(1'b0, 1'b0, 4'(i), 4'h0, 32'h0, 8'(8'h10 + i),
                     (i == 3) ? 32'hDEAD_BEAA : INIT_A, 1'b1);
            begin
                repeat (6) @(posedge clk);
                #1;
                check("credit_stall_ready", bus_a.req_ready, 32'd0);
                check("credit_stall_count", exp_a.size(), 32'd2);
                bus_a.rsp_ready = 1'b1;
            end
        join
        drain();

        // Reset with responses pending, then reset again mid-sweep.
        bus_a.rsp_ready = 1'b0;
        send(1'b0, 1'b0, 4'd1, 4'h0, 32'h0, 8'h51, INIT_A, 1'b1);
        send(1'b0, 1'b0, 4'd2, 4'h0, 32'h0, 8'h52, INIT_A, 1'b1);
        check("pend_valid", bus_a.rsp_valid, 32'd1);
        reset_n = 1'b0;
        #1;
        check("rst_mid_rsp_valid", bus_a.rsp_valid, 32'd0);
        check("rst_mid_ready", bus_a.req_ready, 32'd0);
        check("rst_mid_init_done", init_done_a, 32'd0);
        exp_a.delete();
        exp_b.delete();
        @(negedge clk);
        reset_n = 1'b1;
        repeat (5) @(posedge clk);
        #1;
        check("sweep_mid_addr", ram_addr_a, 32'd5);
        reset_n = 1'b0;
        #1;
        check("rst_sweep_wren", ram_wren_a, 32'h0);
        @(negedge clk);
        reset_n = 1'b1;
        #1;
        check("sweep_restart_addr", ram_addr_a, 32'd0);
        check("sweep_restart_wren", ram_wren_a, 32'hF);
        repeat (16) @(posedge clk);
        #1;
        check("reinit_done", init_done_a, 32'd1);
        bus_a.rsp_ready = 1'b1;
        repeat (4) @(posedge clk);
        #1;
        check("no_stale_rsp", bus_a.rsp_valid, 32'd0);

        // Registered read: response at T+2; write ack ordering on B.
        send(1'b1, 1'b0, 4'd2, 4'h0, 32'h0, 8'h21, INIT_B, 1'b1);
        check("oreg_valid_t1", bus_b.rsp_valid, 32'd0);
        @(posedge clk);
        #1;
        check("oreg_valid_t2", bus_b.rsp_valid, 32'd1);
        check("oreg_tag_t2", bus_b.rsp_tag, 32'h21);
        send(1'b1, 1'b1, 4'd9, 4'hF, 32'h1234_5678, 8'h22, 32'h0, 1'b1);
        send(1'b1, 1'b0, 4'd9, 4'h0, 32'h0, 8'h23, 32'h1234_5678, 1'b1);
        send(1'b1, 1'b0, 4'd9, 4'h0, 32'h0, 8'h30, 32'h1234_5678, 1'b1);
        send(1'b1, 1'b1, 4'd9, 4'h2, 32'h0000_CD00, 8'h31, 32'h0, 1'b1);
        send(1'b1, 1'b0, 4'd9, 4'h0, 32'h0, 8'h32, 32'h1234_CD78, 1'b1);
        drain();

        // Write acks consume credit and return it once consumed.
        bus_b.rsp_ready = 1'b0;
        send(1'b1, 1'b1, 4'd1, 4'hF, 32'hAAAA_5555, 8'h03, 32'h0, 1'b1);
        send(1'b1, 1'b1, 4'd2, 4'hF, 32'h5555_AAAA, 8'h04, 32'h0, 1'b1);
        repeat (3) @(posedge clk);
        #1;
        check("ack_credit_used", bus_b.req_ready, 32'd0);
        bus_b.rsp_ready = 1'b1;
        repeat (4) @(posedge clk);
        #1;
        check("ack_credit_back", bus_b.req_ready, 32'd1);
        check("ack_all_returned", exp_b.size(), 32'd0);
        send(1'b1, 1'b0, 4'd1, 4'h0, 32'h0, 8'h05, 32'hAAAA_5555, 1'b1);
        drain();

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
